// File: rtl/vram_fetch_pkg.sv
// Shared definitions for the video RAM display fetcher: address width and FSM state encoding.
package vram_fetch_pkg;

   localparam int ADDR_W = 15;

   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAITLN = 2'd1,
      ST_FETCH  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/vram_fetch_byte_fifo.sv
// First-word-fall-through byte FIFO. The head byte is visible on rdata whenever count != 0.
// A pop while empty is ignored. Flush takes priority over a same-cycle push or pop.
module vram_fetch_byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [7:0]               wdata,
   input  logic                     pop,
   output logic [7:0]               rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_pop;

   assign do_pop = pop && (count != '0);
   assign rdata  = (count != '0) ? mem[rd_ptr] : 8'h00;

   // Storage needs no reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vram_fetch.sv
// Display-side read initiator for the video RAM: walks a LINES x LINE_BYTES bitmap, one byte per
// granted cycle, and buffers returned bytes in a small FWFT FIFO for the pixel shifter.
module vram_fetch
   import vram_fetch_pkg::*;
#(
   parameter addr_t BASE_ADDR  = 15'h4000,
   parameter int    LINE_BYTES = 40,
   parameter int    LINES      = 200,
   parameter int    FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        line_start,
   input  logic        mem_grant,
   output logic        mem_en,
   output logic [14:0] mem_addr,
   input  logic [7:0]  mem_data,
   input  logic        pix_pop,
   output logic [7:0]  pix_data,
   output logic        pix_valid,
   output logic        underflow,
   output logic        busy
);

   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
   localparam addr_t       LINE_STEP = addr_t'(LINE_BYTES);
   localparam logic [7:0]  LEFT_INIT = 8'(LINE_BYTES);
   localparam logic [9:0]  LINES_N   = 10'(LINES);
   localparam logic [CW:0] DEPTH_N   = (CW+1)'(FIFO_DEPTH);

   state_t        state, state_nx;
   addr_t         addr, addr_nx;
   addr_t         line_base, line_base_nx;
   logic [7:0]    left, left_nx;
   logic [9:0]    line_idx, line_idx_nx;
   logic          inflight;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   occupancy;
   logic          accept;
   addr_t         next_base;
   logic [9:0]    next_idx;
   logic          last_line;

   // Credits count both stored bytes and the one response still on its way back.
   assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
   assign mem_en    = (state == ST_FETCH) && (left != 8'd0) && (occupancy < DEPTH_N);
   assign accept    = mem_en && mem_grant;
   assign mem_addr  = addr;
   assign busy      = (state == ST_FETCH);
   assign pix_valid = (fifo_count != '0);

   assign next_base = line_base + LINE_STEP;
   assign next_idx  = line_idx + 10'd1;
   assign last_line = (next_idx == LINES_N);

   always_comb begin
      state_nx     = state;
      addr_nx      = addr;
      left_nx      = left;
      line_base_nx = line_base;
      line_idx_nx  = line_idx;
      if (frame_start) begin
         state_nx     = ST_WAITLN;
         addr_nx      = BASE_ADDR;
         left_nx      = 8'd0;
         line_base_nx = BASE_ADDR;
         line_idx_nx  = 10'd0;
      end else begin
         case (state)
            ST_WAITLN: begin
               if (line_start) begin
                  state_nx = ST_FETCH;
                  addr_nx  = line_base;
                  left_nx  = LEFT_INIT;
               end
            end
            ST_FETCH: begin
               // A late line_start abandons the rest of the line but keeps the frame geometry.
               if (line_start) begin
                  line_base_nx = next_base;
                  line_idx_nx  = next_idx;
                  if (last_line) begin
                     state_nx = ST_DONE;
                  end else begin
                     addr_nx = next_base;
                     left_nx = LEFT_INIT;
                  end
               end else if (accept) begin
                  addr_nx = addr + 1'b1;
                  left_nx = left - 8'd1;
                  if (left == 8'd1) begin
                     line_base_nx = next_base;
                     line_idx_nx  = next_idx;
                     state_nx     = last_line ? ST_DONE : ST_WAITLN;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         addr      <= BASE_ADDR;
         left      <= 8'd0;
         line_base <= BASE_ADDR;
         line_idx  <= 10'd0;
         inflight  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         state     <= state_nx;
         addr      <= addr_nx;
         left      <= left_nx;
         line_base <= line_base_nx;
         line_idx  <= line_idx_nx;
         inflight  <= accept && !frame_start;
         if (frame_start)
            underflow <= 1'b0;
         else if ((pix_pop && !pix_valid) || (busy && line_start))
            underflow <= 1'b1;
      end
   end

   vram_fetch_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) byte_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (frame_start),
      .push  (inflight && !frame_start),
      .wdata (mem_data),
      .pop   (pix_pop),
      .rdata (pix_data),
      .count (fifo_count)
   );

endmodule
